// File: rtl/hd44780_pkg.sv
// hd44780_pkg
// Shared definitions for the HD44780U pin-level PHY:
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - default bus timing, in ticks
//   - bit positions of the fields inside an instruction word {RS, RWB, DB[7:0]}
//   - beat_data(): the byte placed on DB for a given beat of a write
package hd44780_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ADDR       = 3'd1;
    localparam state_t ST_EN_HIGH    = 3'd2;
    localparam state_t ST_EN_LOW     = 3'd3;
    localparam state_t ST_POLL_CHECK = 3'd4;

    localparam int DEF_ADDR_SETUP_TICKS  = 6;
    localparam int DEF_EN_PW_TICKS       = 45;
    localparam int DEF_EN_CYCLE_TICKS    = 100;
    localparam int DEF_RDATA_DELAY_TICKS = 36;

    localparam int INSTR_RS_IDX  = 9;
    localparam int INSTR_RWB_IDX = 8;
    localparam int INSTR_DB_MSB  = 7;
    localparam int INSTR_DB_LSB  = 0;

    // In 4-bit mode both nibbles travel on DB[7:4], high nibble first.
    function automatic logic [7:0] beat_data(input logic [7:0] db,
                                             input logic       mode_8bit,
                                             input logic       beat);
        if (mode_8bit) begin
            return db;
        end else if (!beat) begin
            return {db[7:4], 4'h0};
        end else begin
            return {db[3:0], 4'h0};
        end
    endfunction

endpackage

// File: rtl/hd44780_tick_gen.sv
// hd44780_tick_gen
// Prescaler plus tick counter used to time every bus phase.
// A tick is max(prescaler_i,1) clocks. restart_i (asserted on the cycle that
// enters a new phase) reloads the prescale period and zeroes both counters, so
// the first cycle of a phase is cycle 0 of tick 0.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   restart_i        restart prescaler and tick count at the next edge
//   prescaler_i      clocks per tick (0 behaves as 1), sampled on restart
//   tick_o           high in the last clock of the current tick
//   tick_count_o     number of completed ticks since the last restart
module hd44780_tick_gen #(
    parameter int PRESCALER_WIDTH = 16,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       restart_i,
    input  logic [PRESCALER_WIDTH-1:0] prescaler_i,
    output logic                       tick_o,
    output logic [CNT_WIDTH-1:0]       tick_count_o
);

    localparam logic [PRESCALER_WIDTH-1:0] P_ONE = PRESCALER_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]       C_ONE = CNT_WIDTH'(1);

    // Stores period-1 so a zero prescaler naturally yields a one-clock tick.
    logic [PRESCALER_WIDTH-1:0] last_q;
    logic [PRESCALER_WIDTH-1:0] presc_cnt_q;

    assign tick_o = (presc_cnt_q == last_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q       <= '0;
            presc_cnt_q  <= '0;
            tick_count_o <= '0;
        end else if (restart_i) begin
            last_q       <= (prescaler_i == '0) ? '0 : prescaler_i - P_ONE;
            presc_cnt_q  <= '0;
            tick_count_o <= '0;
        end else if (tick_o) begin
            presc_cnt_q  <= '0;
            tick_count_o <= tick_count_o + C_ONE;
        end else begin
            presc_cnt_q  <= presc_cnt_q + P_ONE;
        end
    end

endmodule

// File: rtl/hd44780_bus_phy.sv
// hd44780_bus_phy
// Pin-level PHY for an HD44780U panel. Takes one instruction {RS, RWB, DB}
// at a time, runs it as one (8-bit bus) or two (4-bit bus) E beats, optionally
// polls the busy flag after writes, and signals completion with done_o.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   prescaler_i                   clocks per tick (0 treated as 1)
//   phy_enable_i                  allows new instructions to be accepted
//   mode_8bit_i, busy_check_en_i  bus mode / busy polling, latched at accept
//   busy_timeout_i                max busy polls, 0 = no limit
//   err_clr_i, err_busy_timeout_o clear / sticky busy-timeout flag
//   lcd_instr_i, valid_instr_i, ready_instr_o   instruction handshake
//   done_o, rsp_data_o            completion pulse and read/poll byte
//   data_out_o, data_in_i, data_oe_o, rs_o, rwb_o, e_o   panel pins
module hd44780_bus_phy
    import hd44780_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int INSTR_WIDTH       = 10,
    parameter int PRESCALER_WIDTH   = 16,
    parameter int TIMEOUT_WIDTH     = 16,
    parameter int ADDR_SETUP_TICKS  = DEF_ADDR_SETUP_TICKS,
    parameter int EN_PW_TICKS       = DEF_EN_PW_TICKS,
    parameter int EN_CYCLE_TICKS    = DEF_EN_CYCLE_TICKS,
    parameter int RDATA_DELAY_TICKS = DEF_RDATA_DELAY_TICKS
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [PRESCALER_WIDTH-1:0] prescaler_i,
    input  logic                       phy_enable_i,
    input  logic                       mode_8bit_i,
    input  logic                       busy_check_en_i,
    input  logic [TIMEOUT_WIDTH-1:0]   busy_timeout_i,
    input  logic                       err_clr_i,
    input  logic [INSTR_WIDTH-1:0]     lcd_instr_i,
    input  logic                       valid_instr_i,
    output logic                       ready_instr_o,
    output logic                       done_o,
    output logic [DATA_WIDTH-1:0]      rsp_data_o,
    output logic                       err_busy_timeout_o,
    output logic [DATA_WIDTH-1:0]      data_out_o,
    input  logic [DATA_WIDTH-1:0]      data_in_i,
    output logic                       data_oe_o,
    output logic                       rs_o,
    output logic                       rwb_o,
    output logic                       e_o
);

    localparam int CNT_W = $clog2(EN_CYCLE_TICKS + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(ADDR_SETUP_TICKS - 1);
    localparam logic [CNT_W-1:0] EN_HI_LAST  = CNT_W'(EN_PW_TICKS - 1);
    localparam logic [CNT_W-1:0] EN_LO_LAST  = CNT_W'(EN_CYCLE_TICKS - EN_PW_TICKS - 1);
    localparam logic [CNT_W-1:0] RD_SMP_LAST = CNT_W'(RDATA_DELAY_TICKS - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] POLL_ONE = TIMEOUT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic                     beat_q, beat_d;
    logic                     polling_q, polling_d;
    logic [TIMEOUT_WIDTH-1:0] poll_cnt_q, poll_cnt_d, poll_cnt_inc;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     mode_8bit_q, mode_8bit_d;
    logic                     busy_chk_q, busy_chk_d;
    logic [DATA_WIDTH-1:0]    rd_byte_q;
    logic [DATA_WIDTH-1:0]    rsp_d;
    logic                     done_d;
    logic                     err_set;

    logic                     tick;
    logic [CNT_W-1:0]         tick_count;
    logic                     restart;
    logic                     last_beat;

    logic                     rs_nxt, rwb_nxt;
    logic [DATA_WIDTH-1:0]    dout_nxt;

    assign ready_instr_o = phy_enable_i & (state_q == ST_IDLE);
    assign last_beat     = mode_8bit_q | beat_q;
    assign poll_cnt_inc  = poll_cnt_q + POLL_ONE;

    // Every state change is a phase entry, including EN_LOW -> ADDR between beats.
    assign restart = (state_d != state_q);

    hd44780_tick_gen #(
        .PRESCALER_WIDTH (PRESCALER_WIDTH),
        .CNT_WIDTH       (CNT_W)
    ) u_tick_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .restart_i    (restart),
        .prescaler_i  (prescaler_i),
        .tick_o       (tick),
        .tick_count_o (tick_count)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        polling_d   = polling_q;
        poll_cnt_d  = poll_cnt_q;
        instr_d     = instr_q;
        mode_8bit_d = mode_8bit_q;
        busy_chk_d  = busy_chk_q;
        rsp_d       = rsp_data_o;
        done_d      = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_instr_i && ready_instr_o) begin
                    instr_d     = lcd_instr_i;
                    mode_8bit_d = mode_8bit_i;
                    busy_chk_d  = busy_check_en_i;
                    beat_d      = 1'b0;
                    polling_d   = 1'b0;
                    poll_cnt_d  = '0;
                    state_d     = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (tick && tick_count == ADDR_LAST) begin
                    state_d = ST_EN_HIGH;
                end
            end
            ST_EN_HIGH: begin
                if (tick && tick_count == EN_HI_LAST) begin
                    state_d = ST_EN_LOW;
                end
            end
            ST_EN_LOW: begin
                if (tick && tick_count == EN_LO_LAST) begin
                    if (!last_beat) begin
                        beat_d  = 1'b1;
                        state_d = ST_ADDR;
                    end else if (polling_q) begin
                        state_d = ST_POLL_CHECK;
                    end else if (!instr_q[INSTR_RWB_IDX] && busy_chk_q) begin
                        polling_d = 1'b1;
                        beat_d    = 1'b0;
                        state_d   = ST_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        // An unpolled write has no read byte to report.
                        rsp_d   = instr_q[INSTR_RWB_IDX] ? rd_byte_q : '0;
                    end
                end
            end
            ST_POLL_CHECK: begin
                beat_d = 1'b0;
                if (!rd_byte_q[7]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    rsp_d   = rd_byte_q;
                end else begin
                    poll_cnt_d = poll_cnt_inc;
                    if (busy_timeout_i != '0 && poll_cnt_inc == busy_timeout_i) begin
                        err_set = 1'b1;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        rsp_d   = rd_byte_q;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values for the phase being entered; busy polls always read the status register.
    assign rs_nxt   = polling_d ? 1'b0 : instr_d[INSTR_RS_IDX];
    assign rwb_nxt  = polling_d ? 1'b1 : instr_d[INSTR_RWB_IDX];
    assign dout_nxt = beat_data(instr_d[INSTR_DB_MSB:INSTR_DB_LSB], mode_8bit_d, beat_d);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q            <= ST_IDLE;
            beat_q             <= 1'b0;
            polling_q          <= 1'b0;
            poll_cnt_q         <= '0;
            done_o             <= 1'b0;
            rsp_data_o         <= '0;
            err_busy_timeout_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            polling_q  <= polling_d;
            poll_cnt_q <= poll_cnt_d;
            done_o     <= done_d;
            rsp_data_o <= rsp_d;
            if (err_set) begin
                err_busy_timeout_o <= 1'b1;
            end else if (err_clr_i) begin
                err_busy_timeout_o <= 1'b0;
            end
        end
    end

    // Instruction context only matters once accepted, so it carries no reset.
    always_ff @(posedge clk_i) begin
        instr_q     <= instr_d;
        mode_8bit_q <= mode_8bit_d;
        busy_chk_q  <= busy_chk_d;
    end

    // Read capture: whole byte in 8-bit mode, otherwise DB[7:4] into the
    // nibble selected by the beat.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_EN_HIGH && rwb_o && tick && tick_count == RD_SMP_LAST) begin
            if (mode_8bit_q) begin
                rd_byte_q <= data_in_i;
            end else if (!beat_q) begin
                rd_byte_q[7:4] <= data_in_i[7:4];
            end else begin
                rd_byte_q[3:0] <= data_in_i[7:4];
            end
        end
    end

    // Pins load from the next-state decode so they change on phase entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            e_o        <= 1'b0;
            rs_o       <= 1'b0;
            rwb_o      <= 1'b0;
            data_out_o <= '0;
            data_oe_o  <= 1'b0;
        end else begin
            e_o <= (state_d == ST_EN_HIGH);
            if (state_d == ST_ADDR || state_d == ST_EN_HIGH) begin
                rs_o  <= rs_nxt;
                rwb_o <= rwb_nxt;
                if (rwb_nxt) begin
                    data_oe_o <= 1'b0;
                end else begin
                    data_out_o <= dout_nxt;
                    data_oe_o  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hd44780_bus_phy.sv
module tb_hd44780_bus_phy;

    localparam int A     = 6;
    localparam int W     = 45;
    localparam int C     = 100;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [15:0] prescaler_i = 16'd1;
    logic        phy_enable_i = 1'b0;
    logic        mode_8bit_i = 1'b1;
    logic        busy_check_en_i = 1'b0;
    logic [15:0] busy_timeout_i = 16'd0;
    logic        err_clr_i = 1'b0;
    logic [9:0]  lcd_instr_i = '0;
    logic        valid_instr_i = 1'b0;
    logic        ready_instr_o;
    logic        done_o;
    logic [7:0]  rsp_data_o;
    logic        err_busy_timeout_o;
    logic [7:0]  data_out_o;
    logic [7:0]  data_in_i = '0;
    logic        data_oe_o;
    logic        rs_o, rwb_o, e_o;

    always #5 clk = ~clk;

    hd44780_bus_phy dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .prescaler_i        (prescaler_i),
        .phy_enable_i       (phy_enable_i),
        .mode_8bit_i        (mode_8bit_i),
        .busy_check_en_i    (busy_check_en_i),
        .busy_timeout_i     (busy_timeout_i),
        .err_clr_i          (err_clr_i),
        .lcd_instr_i        (lcd_instr_i),
        .valid_instr_i      (valid_instr_i),
        .ready_instr_o      (ready_instr_o),
        .done_o             (done_o),
        .rsp_data_o         (rsp_data_o),
        .err_busy_timeout_o (err_busy_timeout_o),
        .data_out_o         (data_out_o),
        .data_in_i          (data_in_i),
        .data_oe_o          (data_oe_o),
        .rs_o               (rs_o),
        .rwb_o              (rwb_o),
        .e_o                (e_o)
    );

    typedef struct {
        logic       rs;
        logic       rwb;
        logic [7:0] dout;
        logic       oe;
        int         rise;
        int         width;
    } beat_t;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_bad = 0;
    beat_t      seen_q[$];
    beat_t      cur;
    logic [7:0] rdq[$];
    logic       e_prev = 1'b0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] done_rsp = '0;
    logic       done_err = 1'b0;
    logic       model_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the pins half a cycle after each edge: log every E pulse, feed
    // read data on each read beat, and record completions.
    always @(negedge clk) begin
        if (e_o === 1'b1 && e_prev === 1'b0) begin
            cur.rs    = rs_o;
            cur.rwb   = rwb_o;
            cur.dout  = data_out_o;
            cur.oe    = data_oe_o;
            cur.rise  = cyc;
            cur.width = 0;
            if (rwb_o) data_in_i = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
        end
        if (e_o === 1'b0 && e_prev === 1'b1) begin
            cur.width = cyc - cur.rise;
            seen_q.push_back(cur);
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_rsp = rsp_data_o;
            done_err = err_busy_timeout_o;
        end
        e_prev = e_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A byte the panel returns, as it appears on DB over one or two read beats.
    task automatic push_rd(input logic [7:0] v, input logic m8);
        logic [3:0] junk;
        if (m8) begin
            rdq.push_back(v);
        end else begin
            junk = 4'($urandom);
            rdq.push_back({v[7:4], junk});
            junk = 4'($urandom);
            rdq.push_back({v[3:0], junk});
        end
    endtask

    // Issue one instruction and compare the observed pin activity with the
    // beats, timing and response that the bus rules predict.
    task automatic run_instr(input logic [9:0] ins, input logic m8, input logic bchk,
                             input logic [15:0] p, input logic [15:0] tmo, input int nbusy,
                             input logic [7:0] rdv, input logic drop_en);
        beat_t      exp_q[$];
        beat_t      eb;
        int         pe, nb, npoll, acc, n;
        logic [7:0] exp_rsp, pb;
        logic       exp_err, chk_rsp, timed;
        pe      = (p == 0) ? 1 : int'(p);
        nb      = m8 ? 1 : 2;
        exp_err = 1'b0;
        chk_rsp = 1'b0;
        exp_rsp = '0;
        timed   = ins[8] || !bchk;
        @(negedge clk);
        seen_q.delete();
        rdq.delete();
        done_cnt = 0;
        for (int b = 0; b < nb; b++) begin
            eb.rs    = ins[9];
            eb.rwb   = ins[8];
            eb.dout  = m8 ? ins[7:0] : ((b == 0) ? {ins[7:4], 4'h0} : {ins[3:0], 4'h0});
            eb.oe    = !ins[8];
            eb.rise  = 0;
            eb.width = 0;
            exp_q.push_back(eb);
        end
        if (ins[8]) begin
            push_rd(rdv, m8);
            exp_rsp = rdv;
            chk_rsp = 1'b1;
        end else if (bchk) begin
            exp_err = (tmo != 0) && (nbusy >= int'(tmo));
            npoll   = exp_err ? int'(tmo) : nbusy + 1;
            for (int k = 0; k < npoll; k++) begin
                pb = 8'($urandom);
                pb[7] = (k < nbusy);
                push_rd(pb, m8);
                exp_rsp = pb;
                for (int b = 0; b < nb; b++) begin
                    eb.rs = 1'b0; eb.rwb = 1'b1; eb.dout = '0; eb.oe = 1'b0;
                    exp_q.push_back(eb);
                end
            end
            chk_rsp = 1'b1;
        end
        prescaler_i     = p;
        mode_8bit_i     = m8;
        busy_check_en_i = bchk;
        busy_timeout_i  = tmo;
        lcd_instr_i     = ins;
        valid_instr_i   = 1'b1;
        n = 0;
        while (ready_instr_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready", ready_instr_o, 1);
        acc = cyc;
        @(negedge clk);
        valid_instr_i   = 1'b0;
        lcd_instr_i     = 10'($urandom);
        mode_8bit_i     = 1'($urandom);
        busy_check_en_i = 1'($urandom);
        if (drop_en) phy_enable_i = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
        repeat (4) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("nbeats", seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            chk("beat_rs", seen_q[i].rs, exp_q[i].rs);
            chk("beat_rwb", seen_q[i].rwb, exp_q[i].rwb);
            chk("beat_oe", seen_q[i].oe, exp_q[i].oe);
            if (exp_q[i].oe) chk("beat_data", seen_q[i].dout, exp_q[i].dout);
            chk("e_width", seen_q[i].width, W * pe);
            if (timed) chk("e_rise", seen_q[i].rise, acc + 1 + A * pe + i * (A + C) * pe);
        end
        if (timed) chk("done_cycle", done_cyc, acc + nb * (A + C) * pe + 1);
        if (chk_rsp) chk("rsp_data", done_rsp, exp_rsp);
        model_err = model_err | exp_err;
        chk("err_flag", done_err, model_err);
        if (drop_en) phy_enable_i = 1'b1;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_e", e_o, 0);
        chk("rst_rs", rs_o, 0);
        chk("rst_rwb", rwb_o, 0);
        chk("rst_dout", data_out_o, 0);
        chk("rst_oe", data_oe_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rsp", rsp_data_o, 0);
        chk("rst_err", err_busy_timeout_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("ready_disabled", ready_instr_o, 0);
        lcd_instr_i   = 10'h038;
        valid_instr_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_beat_disabled", seen_q.size(), 0);
        valid_instr_i = 1'b0;
        phy_enable_i  = 1'b1;
        @(negedge clk);
        chk("ready_enabled", ready_instr_o, 1);

        run_instr(10'h038, 1'b1, 1'b0, 16'd1, 16'd0, 0, 8'h00, 1'b0);
        run_instr(10'h2A5, 1'b0, 1'b0, 16'd2, 16'd0, 0, 8'h00, 1'b0);
        run_instr(10'h300, 1'b0, 1'b0, 16'd1, 16'd0, 0, 8'hC7, 1'b0);
        run_instr(10'h038, 1'b1, 1'b1, 16'd1, 16'd0, 3, 8'h00, 1'b1);
        run_instr(10'h001, 1'b1, 1'b1, 16'd1, 16'd4, 10, 8'h00, 1'b0);

        // Reset in the middle of an E pulse of a write.
        @(negedge clk);
        prescaler_i   = 16'd1;
        mode_8bit_i   = 1'b1;
        lcd_instr_i   = 10'h2FF;
        valid_instr_i = 1'b1;
        @(negedge clk);
        valid_instr_i = 1'b0;
        n = 0;
        while (e_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_e_high", e_o, 1);
        repeat (5) @(negedge clk);
        done_cnt = 0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        model_err = 1'b0;
        chk("mrst_e", e_o, 0);
        chk("mrst_rs", rs_o, 0);
        chk("mrst_dout", data_out_o, 0);
        chk("mrst_oe", data_oe_o, 0);
        chk("mrst_rsp", rsp_data_o, 0);
        chk("mrst_err", err_busy_timeout_o, 0);
        chk("mrst_ready", ready_instr_o, 1);
        repeat (200) @(negedge clk);
        chk("mrst_no_done", done_cnt, 0);
        run_instr(10'h1C3, 1'b1, 1'b0, 16'd0, 16'd0, 0, 8'h00, 1'b0);

        // Timeout set while a clear is held: the set must win on that edge.
        err_clr_i = 1'b1;
        run_instr(10'h0F0, 1'b0, 1'b1, 16'd1, 16'd2, 9, 8'h00, 1'b0);
        err_clr_i = 1'b0;
        model_err = 1'b0;
        chk("err_clr_held", err_busy_timeout_o, 0);

        run_instr(10'h055, 1'b1, 1'b1, 16'd1, 16'd1, 1, 8'h00, 1'b0);
        chk("err_sticky", err_busy_timeout_o, 1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        model_err = 1'b0;
        chk("err_cleared", err_busy_timeout_o, 0);

        for (int t = 0; t < 12; t++) begin
            run_instr(10'($urandom), 1'($urandom), 1'($urandom), 16'($urandom_range(0, 2)),
                      16'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 8'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hd44780_bus_phy.md
# hd44780_bus_phy

Second-generation HD44780U pin-level PHY. It sits between the LCD instruction queue and the panel pins, and adds runtime 4-bit/8-bit bus mode, parametrised bus timing, and optional automatic busy-flag polling with a timeout error. Each accepted instruction runs as one or two enable (E) beats, plus any busy polls, and ends with a one-cycle completion response.

## Interface
Parameters:
- DATA_WIDTH, 8, LCD data bus width; fixed at 8, and 4-bit mode uses bits [7:4].
- INSTR_WIDTH, 10, instruction width: {RS, RWB, DB[7:0]}.
- PRESCALER_WIDTH, 16, width of the clock-per-tick prescaler (1 tick = 10 ns nominal).
- TIMEOUT_WIDTH, 16, width of the busy-poll timeout count.
- ADDR_SETUP_TICKS, 6, RS/RWB setup time before E rises.
- EN_PW_TICKS, 45, E high pulse width.
- EN_CYCLE_TICKS, 100, E rise-to-next-rise minimum; E low lasts EN_CYCLE_TICKS-EN_PW_TICKS.
- RDATA_DELAY_TICKS, 36, delay from E rise to the read-sample point; must be below EN_PW_TICKS.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- prescaler_i  in  PRESCALER_WIDTH  clocks per tick; value 0 is treated as 1
- phy_enable_i  in  1  gates acceptance of new instructions only
- mode_8bit_i  in  1  1 = 8-bit bus, 0 = 4-bit bus; sampled at accept
- busy_check_en_i  in  1  poll the busy flag after writes; sampled at accept
- busy_timeout_i  in  TIMEOUT_WIDTH  maximum number of polls; 0 disables the timeout
- err_clr_i  in  1  clears err_busy_timeout_o
- lcd_instr_i  in  INSTR_WIDTH  instruction
- valid_instr_i  in  1  instruction valid
- ready_instr_o  out  1  instruction ready
- done_o  out  1  one-cycle completion pulse
- rsp_data_o  out  8  assembled read data (reads) or last busy-read byte (polled writes)
- err_busy_timeout_o  out  1  sticky timeout flag
- data_out_o  out  8  DB drive value
- data_in_i  in  8  DB sampled value
- data_oe_o  out  1  DB output enable
- rs_o, rwb_o, e_o  out  1 each  LCD control pins

## Operation
- Acceptance:
  - ready_instr_o = phy_enable_i & (state == IDLE).
  - An instruction is accepted on a cycle where valid_instr_i & ready_instr_o is high.
  - The instruction, mode_8bit_i and busy_check_en_i are latched at accept.
- Beat sequence: every E beat runs ADDR, then EN_HIGH, then EN_LOW, and then returns to IDLE.
  - ADDR: drive rs_o and rwb_o; e_o=0. A read beat drives data_oe_o=0.
  - EN_HIGH: e_o=1.
    - Write beat: data_out_o holds the beat data and data_oe_o=1.
    - Read beat: data_in_i is sampled in the last cycle of tick RDATA_DELAY_TICKS.
  - EN_LOW: e_o=0. data_out_o and data_oe_o hold their values.
- 8-bit mode: one beat carrying the full byte.
- 4-bit mode: two beats. Beat 0 carries DB[7:4] and beat 1 carries DB[3:0], both on data_out_o[7:4]; data_out_o[3:0]=0.
  - Reads capture data_in_i[7:4] into rsp_data_o[7:4] on beat 0, then into [3:0] on beat 1.
- Busy poll: runs after a write (RWB=0) completes, if busy_check_en_i was latched high.
  - Each poll is a read transaction with rs=0, rwb=1, using the same beat count as the current mode.
  - If bit 7 of the assembled byte is 0, the instruction completes.
  - Otherwise, increment the poll count. If busy_timeout_i≠0 and the count equals busy_timeout_i, set err_busy_timeout_o and complete; otherwise poll again.
- Completion: done_o pulses for one cycle, in the same cycle the block re-enters IDLE. rsp_data_o updates on that cycle and holds until the next completion.
- err_busy_timeout_o is cleared by err_clr_i or by reset. If a set and a clear occur in the same cycle, the set wins.
- Deasserting phy_enable_i mid-instruction does not abort the instruction; it only blocks new accepts.
- Reset asserted mid-instruction: all state and outputs take their reset values on the next clock edge; the partial instruction is dropped with no done_o.

## Timing
- Reset values: e_o=0, rs_o=0, rwb_o=0, data_out_o=0, data_oe_o=0, done_o=0, rsp_data_o=0, err_busy_timeout_o=0. After reset, ready_instr_o=phy_enable_i.
- A tick lasts P = max(prescaler_i,1) clocks. Each phase lasts exactly N×P clocks. The prescaler and tick counter restart on every phase entry.
- Pin flops load from next-state decode, so pin changes coincide with state entry.
- With accept at cycle 0, for each beat:
  - rs_o and rwb_o are valid from cycle 1.
  - e_o is high over cycles [1+A·P, A·P+W·P].
  - The beat occupies (A+C)·P cycles, where A = ADDR_SETUP_TICKS, W = EN_PW_TICKS, C = EN_CYCLE_TICKS.
- A plain 8-bit write completes with done_o at cycle (A+C)·P+1. Defaults with P=1 give 107.
- A back-to-back accept is possible in the same cycle done_o fires. The next beat's ADDR phase then starts the following cycle, so the E cycle stays at or above C.
- prescaler_i changes take effect at the next phase entry.

## Structure
- Package hd44780_pkg holds:
  - the state enum (IDLE, ADDR, EN_HIGH, EN_LOW, POLL_CHECK);
  - the default tick constants;
  - instruction field index localparams.
- One sub-module, hd44780_tick_gen: prescaler plus tick counter, with a restart input and a tick_count output.
- The beat and poll counters stay in the top module.

## Test plan
- 8-bit write 0x0_38, P=1, polling off -> one E pulse of 45 cycles, data_out_o=0x38, data_oe_o=1, done_o at cycle 107.
- 4-bit write 0x2_A5, P=2 -> two E pulses with data_out_o=0xA0 then 0x50, rs_o=1, done_o at cycle 425.
- 4-bit read 0x3_00 with data_in_i=0xC0 on beat 0 and 0x70 on beat 1 -> rsp_data_o=0xC7, done_o once.
- Polled write with busy asserted for 3 polls -> exactly 3 busy reads plus 1 clean read (rs_o=0, rwb_o=1), done_o once, error flag 0.
- Polled write, busy stuck high, busy_timeout_i=4 -> 4 polls, err_busy_timeout_o=1, done_o once; err_clr_i clears the flag.
- rst_i pulsed during EN_HIGH of a write -> next cycle all outputs are at reset values, no done_o, and the next instruction is accepted normally.
